// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: drives all eight {A,B,C} vectors into a 3-in/1-out block,
// samples D at the end of each dwell and records a per-vector fail map.
module truth_table_sequencer #(
  parameter int DWELL = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       d_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_map,
  output logic [3:0] err_count
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    exp_q, exp_d;
  logic [7:0]    fail_q, fail_d;
  logic [3:0]    err_q, err_d;
  logic [2:0]    abc_q, abc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  // next-state: accept start when idle/done, step dwell/vector and compare in DRIVE
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    fail_d  = fail_q;
    err_d   = err_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          exp_d   = expected;
          fail_d  = 8'h00;
          err_d   = 4'd0;
          vec_d   = 3'd0;
          cnt_d   = '0;
          abc_d   = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (d_in != exp_q[vec_q]) begin
            fail_d[vec_q] = 1'b1;
            err_d = err_q + 4'd1;
          end
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
          end else begin
            // last vector compared: results are final this edge
            state_d = DONE;
            abc_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_d == 8'h00);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      exp_q   <= 8'h00;
      fail_q  <= 8'h00;
      err_q   <= 4'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = abc_q[2];
  assign b_out     = abc_q[1];
  assign c_out     = abc_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_map  = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: two instances (DWELL=20 and DWELL=1) checked
// cycle by cycle against a truth-table level reference model.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [7:0] expv [2];
  logic [7:0] resp [2];
  logic [1:0] glitch = 2'b00;
  logic [1:0] dv;
  logic [1:0] a, b, c, busy, done, pass;
  logic [7:0] fm [2];
  logic [3:0] ec [2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // emulated block under test: response table indexed by the applied vector
  assign dv[0] = resp[0][{a[0], b[0], c[0]}] ^ glitch[0];
  assign dv[1] = resp[1][{a[1], b[1], c[1]}] ^ glitch[1];

  truth_table_sequencer #(.DWELL(20)) u_d20 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .expected(expv[0]),
    .d_in(dv[0]), .a_out(a[0]), .b_out(b[0]), .c_out(c[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_map(fm[0]), .err_count(ec[0])
  );

  truth_table_sequencer #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .expected(expv[1]),
    .d_in(dv[1]), .a_out(a[1]), .b_out(b[1]), .c_out(c[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_map(fm[1]), .err_count(ec[1])
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vecs++;
      if ({a[u], b[u], c[u], busy[u], done[u], pass[u], fm[u], ec[u]} !== 18'd0) begin
        errs++;
        $display("FAIL reset u%0d: abc=%b busy=%b done=%b pass=%b fm=%h ec=%0d, want all 0",
                 u, {a[u], b[u], c[u]}, busy[u], done[u], pass[u], fm[u], ec[u]);
      end
    end
    rst_n = 1'b1;
  endtask

  // one full run on unit u; bd = restart pulse + expected change mid-run,
  // gl = random d_in glitches outside the compare cycle
  task automatic test_run(input int u, input logic [7:0] e, input logic [7:0] r,
                          input bit bd, input bit gl);
    int d;
    int tot;
    int k;
    logic [7:0] ef, m, fme;
    logic [2:0] abc_e;
    logic busy_e, done_e, pass_e;
    d = (u == 1) ? 1 : 20;
    tot = 8 * d;
    ef = e ^ r;
    @(negedge clk);
    expv[u] = e;
    resp[u] = r;
    start[u] = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= tot; n++) begin
      @(negedge clk);
      start[u] = 1'b0;
      glitch[u] = 1'b0;
      k = n / d;
      m = (k >= 8) ? 8'hFF : 8'((9'd1 << k) - 9'd1);
      fme = ef & m;
      busy_e = (n < tot);
      done_e = (n == tot);
      pass_e = done_e && (ef == 8'h00);
      abc_e = (n < tot) ? 3'(k) : 3'd0;
      vecs++;
      if ({a[u], b[u], c[u]} !== abc_e) begin
        errs++;
        $display("FAIL abc u%0d n=%0d: got %b want %b", u, n, {a[u], b[u], c[u]}, abc_e);
      end
      vecs++;
      if ({busy[u], done[u], pass[u]} !== {busy_e, done_e, pass_e}) begin
        errs++;
        $display("FAIL flags u%0d n=%0d: busy/done/pass got %b want %b",
                 u, n, {busy[u], done[u], pass[u]}, {busy_e, done_e, pass_e});
      end
      vecs++;
      if (fm[u] !== fme || ec[u] !== 4'($countones(fme))) begin
        errs++;
        $display("FAIL results u%0d n=%0d: fm=%h ec=%0d want fm=%h ec=%0d",
                 u, n, fm[u], ec[u], fme, $countones(fme));
      end
      if (n < tot) begin
        if (bd && n == 3 * d) start[u] = 1'b1;
        if (bd && n >= 1) expv[u] = 8'h00;
        if (gl && ((n + 1) % d) != 0) glitch[u] = 1'($urandom_range(0, 1));
      end
    end
    start[u] = 1'b0;
    glitch[u] = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    expv[0] = 8'hE8;
    resp[0] = 8'hE8;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (64) @(negedge clk);
    vecs++;
    if ({a[0], b[0], c[0], busy[0]} !== 4'b0111) begin
      errs++;
      $display("FAIL midrun_pre: abc=%b busy=%b want 011 1", {a[0], b[0], c[0]}, busy[0]);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({a[0], b[0], c[0], busy[0], done[0], pass[0], fm[0], ec[0]} !== 18'd0) begin
      errs++;
      $display("FAIL midrun_reset: abc=%b busy=%b done=%b pass=%b fm=%h ec=%0d want 0",
               {a[0], b[0], c[0]}, busy[0], done[0], pass[0], fm[0], ec[0]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      vecs++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errs++;
        $display("FAIL midrun_idle i=%0d: done=%b busy=%b want 0 0", i, done[0], busy[0]);
      end
    end
    test_run(0, 8'hE8, 8'hE8, 1'b0, 1'b0);
  endtask

  task automatic test_dwell1_restart();
    test_run(1, 8'h96, 8'h96, 1'b0, 1'b0);
    test_run(1, 8'h96, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_run(i % 2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    expv[0] = 8'h00;
    expv[1] = 8'h00;
    resp[0] = 8'h00;
    resp[1] = 8'h00;
    test_reset();
    test_run(0, 8'hE8, 8'hE8, 1'b0, 1'b0);
    test_run(0, 8'hE8, 8'h00, 1'b0, 1'b0);
    test_run(0, 8'hE8, 8'hE8, 1'b1, 1'b1);
    test_reset_midrun();
    test_dwell1_restart();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Self-checking exhaustive stimulus and response stage for a 3-input, 1-output combinational block such as `simple_circuit2`. It sits directly around that block.
- Upstream, it drives the A, B, C inputs through all eight combinations in binary order, holding each for a programmable dwell.
- Downstream, it samples the D output at the end of each dwell and compares it against an 8-bit expected truth table.
- It reports a per-vector fail map, an error count and a pass/done flag.

It replaces hand-written `#20` stimulus sequences with a reusable, clocked, synthesizable stage.

## Interface
- DWELL, 20, clock cycles each input vector is held (≥1); D is sampled on the last cycle of the dwell.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  level-sampled; starts a run when high in IDLE or DONE.
- expected  input  8  expected D per vector; bit k = expected D for {A,B,C}=k. Latched at start.
- d_in  input  1  D output of the block under test.
- a_out  output  1  A drive (vector bit 2).
- b_out  output  1  B drive (vector bit 1).
- c_out  output  1  C drive (vector bit 0).
- busy  output  1  high while vectors are being applied.
- done  output  1  high from run completion until next start or reset.
- pass  output  1  high only when done=1 and fail_map==0.
- fail_map  output  8  bit k set if vector k mismatched.
- err_count  output  4  number of mismatching vectors, 0..8.

## Operation
- States: IDLE, DRIVE, DONE.
- Reset (rst_n=0 at an edge) forces the following, regardless of state:
  - state=IDLE.
  - a/b/c_out=000.
  - busy=0, done=0, pass=0.
  - fail_map=8'h00, err_count=0.
  - internal vector index vec=0, dwell counter cnt=0.
- IDLE: a/b/c_out=000.
  - start=1 at an edge latches expected into exp_q, clears fail_map/err_count, sets vec=0 and cnt=0, and goes to DRIVE.
- DRIVE: {a_out,b_out,c_out}=vec; busy=1.
  - cnt<DWELL-1: cnt increments.
  - cnt==DWELL-1: d_in is sampled and compared with exp_q[vec].
    - On mismatch, fail_map[vec] is set and err_count increments.
    - If vec<7: vec increments and cnt returns to 0.
    - If vec==7: go to DONE.
- DONE: a/b/c_out=000; busy=0; done=1; pass=(fail_map==0).
  - Results hold.
  - start=1 behaves exactly as in IDLE: clear results and restart. done drops at that edge.
- Behaviour while busy:
  - start is ignored in DRIVE.
  - Changes on expected after the start edge do not affect the run.
- d_in is sampled only at the single compare edge per vector. Glitches or values at other cycles have no effect.
- Counter widths:
  - cnt is wide enough for DWELL-1, minimum 1 bit.
  - vec is 3 bits and never wraps: DONE is entered instead.
  - err_count cannot exceed 8.

## Timing
- Let E0 be the edge where start is accepted. Outputs after E0:
  - busy=1.
  - vector 0 visible on a/b/c_out.
- Vector k is driven for edges E0..E0+DWELL-1 relative to its own start, DWELL cycles total.
- The compare for vector k occurs at edge E0+(k+1)·DWELL, using d_in in the preceding cycle.
- Vector k+1 appears after that same edge.
- With DWELL=1, d_in must settle combinationally within the cycle.
- Completion:
  - After edge E0+8·DWELL: busy=0, done=1, pass/fail_map/err_count final.
  - The run lasts exactly 8·DWELL busy cycles.
- Result registers update at the compare edge. fail_map and err_count are visible mid-run, but pass is asserted only in DONE.
- Reset mid-run: all outputs take their reset values after the reset edge. No partial done is produced. The next start runs a complete fresh sequence.

## Test plan
- Reset: hold rst_n=0 for 2 edges in any state. Required: a/b/c_out=000, busy=0, done=0, pass=0, fail_map=00, err_count=0.
- Good DUT, DWELL=20, expected=8'hE8, d_in driven by a majority-of-A,B,C model. Required:
  - a/b/c_out step 000→111 every 20 cycles.
  - done=1 exactly 160 cycles after the start edge.
  - pass=1, fail_map=00, err_count=0.
- Faulty DUT: d_in stuck at 0, expected=8'hE8. Required: fail_map=8'hE8, err_count=4, pass=0, done=1.
- Busy robustness:
  - Pulse start again at vector 3, and change expected to 8'h00 mid-run.
  - Required: run is unaffected and completes at 160 cycles with results from 8'hE8.
  - Glitch d_in away from the compare edge: no error recorded.
- Reset mid-run: assert rst_n=0 during vector 3. Required: outputs return to reset values, done never rises. A later start completes a full run with correct results.
- DWELL=1 and restart:
  - Run with expected=8'h96 and an XOR model: done after 8 cycles, pass=1.
  - Start in DONE with d_in stuck at 1: done drops at the start edge.
  - Required after the second run: fail_map=8'h69, err_count=4.
